// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if: bundles the decode descriptor, the shared-ALU handshake and the next-PC result.
// slave modport = the sequencer; master modport = the decode/ALU/fetch environment around it.
// in_valid/in_ready/in_kind/in_func3/in_pc/in_imm/in_rs1 : descriptor (valid/ready)
// alu_req/alu_func3/alu_gnt/alu_done/alu_zero               : shared ALU request/grant/result
// pc/done/redirect/taken/timeout_err                        : architectural PC and retirement pulses
interface branch_sequencer_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      in_kind;
   logic [2:0]      in_func3;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_imm;
   logic [XLEN-1:0] in_rs1;
   logic            alu_req;
   logic [2:0]      alu_func3;
   logic            alu_gnt;
   logic            alu_done;
   logic            alu_zero;
   logic [XLEN-1:0] pc;
   logic            done;
   logic            redirect;
   logic            taken;
   logic            timeout_err;

   modport slave (
      input  in_valid, in_kind, in_func3, in_pc, in_imm, in_rs1,
      input  alu_gnt, alu_done, alu_zero,
      output in_ready, alu_req, alu_func3,
      output pc, done, redirect, taken, timeout_err
   );

   modport master (
      output in_valid, in_kind, in_func3, in_pc, in_imm, in_rs1,
      output alu_gnt, alu_done, alu_zero,
      input  in_ready, alu_req, alu_func3,
      input  pc, done, redirect, taken, timeout_err
   );
endinterface

// File: rtl/branch_sequencer.sv
// branch_sequencer: owns the architectural PC; retires seq/jal/jalr directly, resolves branches via the shared ALU.
// Latency: seq/jal/jalr and func3 010/011 retire on the accepting edge; branches retire >= 2 edges later (+1 per gnt/done stall).
// Backpressure: in_ready is high only in IDLE, so no descriptor is taken while a branch waits for grant or result.
// Ports: clk, rst_n (async active-low), bus (branch_sequencer_if.slave).
// Optional: define BRSEQ_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT cycles (retire as not-taken, pulse timeout_err).
module branch_sequencer #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
   parameter int              TIMEOUT  = 16
) (
   input logic               clk,
   input logic               rst_n,
   branch_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   localparam logic [1:0] K_SEQ  = 2'b00;
   localparam logic [1:0] K_BR   = 2'b01;
   localparam logic [1:0] K_JAL  = 2'b10;
   localparam logic [1:0] K_JALR = 2'b11;

   localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
   localparam logic [XLEN-1:0] LSB_MASK = {{(XLEN-1){1'b1}}, 1'b0};

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] target_q;
   logic [XLEN-1:0] fall_q;
   logic [2:0]      func3_q;
   logic            done_q;
   logic            redirect_q;
   logic            taken_q;

   logic accept;
   logic br_legal;
   logic start_br;
   logic seq_retire;
   logic cond_taken;
   logic wait_done;
   logic wait_tmo;

   assign accept     = bus.in_valid && (state_q == ST_IDLE);
   // func3 010/011 are not RISC-V branch encodings; they retire as plain fall-through
   assign br_legal   = (bus.in_func3 != 3'b010) && (bus.in_func3 != 3'b011);
   assign start_br   = accept && (bus.in_kind == K_BR) && br_legal;
   assign seq_retire = accept && ((bus.in_kind == K_SEQ) || ((bus.in_kind == K_BR) && !br_legal));
   // BEQ/BGE/BGEU take on a zero result (equal / not-less); BNE/BLT/BLTU take on non-zero
   assign cond_taken = ((func3_q == 3'b000) || (func3_q == 3'b101) || (func3_q == 3'b111))
                       ? bus.alu_zero : ~bus.alu_zero;
   assign wait_done  = (state_q == ST_WAIT) && bus.alu_done;

`ifdef BRSEQ_TIMEOUT_EN
   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] tmo_cnt_q;
   logic          timeout_q;

   // counts WAIT cycles without a result; abort fires on the edge the count would reach TIMEOUT,
   // and a result arriving on that same edge wins because wait_tmo requires !alu_done
   assign wait_tmo = (state_q == ST_WAIT) && !bus.alu_done && (tmo_cnt_q == TMO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= wait_tmo;
         if ((state_q == ST_REQ) && bus.alu_gnt) begin
            tmo_cnt_q <= '0;
         end else if ((state_q == ST_WAIT) && !bus.alu_done) begin
            tmo_cnt_q <= tmo_cnt_q + CW'(1);
         end
      end
   end

   assign bus.timeout_err = timeout_q;
`else
   // TIMEOUT only matters when the abort counter is built
   logic unused_timeout;
   assign unused_timeout  = ^TIMEOUT;
   assign wait_tmo        = 1'b0;
   assign bus.timeout_err = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic; alu_gnt only matters in REQ, alu_done only in WAIT
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_br)              state_d = ST_REQ;
         ST_REQ:  if (bus.alu_gnt)           state_d = ST_WAIT;
         ST_WAIT: if (wait_done || wait_tmo) state_d = ST_IDLE;
         default:                            state_d = ST_IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      bus.in_ready  = (state_q == ST_IDLE);
      bus.alu_req   = (state_q == ST_REQ);
      bus.alu_func3 = func3_q;
   end

   // PC, branch context and retirement pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         target_q   <= '0;
         fall_q     <= '0;
         func3_q    <= 3'b000;
         done_q     <= 1'b0;
         redirect_q <= 1'b0;
         taken_q    <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         redirect_q <= 1'b0;
         if (seq_retire) begin
            pc_q    <= bus.in_pc + PC_STEP;
            taken_q <= 1'b0;
            done_q  <= 1'b1;
         end else if (accept && (bus.in_kind == K_JAL)) begin
            pc_q       <= bus.in_pc + bus.in_imm;
            taken_q    <= 1'b1;
            redirect_q <= 1'b1;
            done_q     <= 1'b1;
         end else if (accept && (bus.in_kind == K_JALR)) begin
            pc_q       <= (bus.in_rs1 + bus.in_imm) & LSB_MASK;
            taken_q    <= 1'b1;
            redirect_q <= 1'b1;
            done_q     <= 1'b1;
         end else if (start_br) begin
            func3_q  <= bus.in_func3;
            target_q <= bus.in_pc + bus.in_imm;
            fall_q   <= bus.in_pc + PC_STEP;
         end else if (wait_done) begin
            pc_q       <= cond_taken ? target_q : fall_q;
            taken_q    <= cond_taken;
            redirect_q <= cond_taken;
            done_q     <= 1'b1;
         end else if (wait_tmo) begin
            pc_q    <= fall_q;
            taken_q <= 1'b0;
            done_q  <= 1'b1;
         end
      end
   end

   assign bus.pc       = pc_q;
   assign bus.done     = done_q;
   assign bus.redirect = redirect_q;
   assign bus.taken    = taken_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed scenarios plus randomized descriptors checked against a behavioural model.
// The model derives branch outcomes from real RISC-V operand comparisons and feeds the DUT the zero flag an ALU would produce.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_branch_sequencer;
   localparam int          XLEN   = 32;
   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam int          TMO    = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   branch_sequencer_if #(.XLEN(XLEN)) bif ();

   branch_sequencer #(.XLEN(XLEN), .RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got time %0t want below 400000", $time);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic issue(input logic [1:0] kind, input logic [2:0] f3,
                        input logic [31:0] ipc, input logic [31:0] imm, input logic [31:0] rs1);
      bif.in_valid = 1'b1;
      bif.in_kind  = kind;
      bif.in_func3 = f3;
      bif.in_pc    = ipc;
      bif.in_imm   = imm;
      bif.in_rs1   = rs1;
      step();
      bif.in_valid = 1'b0;
   endtask

   // Open-loop ALU: gdly cycles before grant, ddly WAIT cycles before the result.
   // With noise, spurious done during REQ and spurious gnt during WAIT must both be ignored.
   task automatic resolve(input int gdly, input int ddly, input logic zero, input logic noise);
      for (int i = 0; i < gdly; i++) begin
         bif.alu_gnt = 1'b0;
         if (noise) begin
            bif.alu_done = 1'($urandom);
            bif.alu_zero = 1'($urandom);
         end
         step();
      end
      bif.alu_done = 1'b0;
      bif.alu_gnt  = 1'b1;
      step();
      bif.alu_gnt = 1'b0;
      for (int i = 0; i < ddly; i++) begin
         if (noise) bif.alu_gnt = 1'($urandom);
         step();
      end
      bif.alu_gnt  = 1'b0;
      bif.alu_done = 1'b1;
      bif.alu_zero = zero;
      step();
      bif.alu_done = 1'b0;
   endtask

   // Reference: next PC and taken flag from architectural rules; zero is what a SUB/SLT/SLTU ALU returns.
   function automatic void ref_model(input logic [1:0] kind, input logic [2:0] f3,
                                     input logic [31:0] ipc, input logic [31:0] imm, input logic [31:0] rs1,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] npc, output logic tk,
                                     output logic zero, output logic is_br);
      logic eq, lt_s, lt_u;
      eq    = (a == b);
      lt_s  = $signed(a) < $signed(b);
      lt_u  = a < b;
      zero  = f3[2] ? !(f3[1] ? lt_u : lt_s) : eq;
      is_br = (kind == 2'b01) && (f3 != 3'd2) && (f3 != 3'd3);
      tk    = 1'b0;
      npc   = ipc + 32'd4;
      case (kind)
         2'b10: begin npc = ipc + imm; tk = 1'b1; end
         2'b11: begin npc = (rs1 + imm) & 32'hFFFF_FFFE; tk = 1'b1; end
         2'b01: begin
            if (is_br) begin
               case (f3)
                  3'd0:    tk = eq;
                  3'd1:    tk = !eq;
                  3'd4:    tk = lt_s;
                  3'd5:    tk = !lt_s;
                  3'd6:    tk = lt_u;
                  default: tk = !lt_u;
               endcase
               npc = tk ? ipc + imm : ipc + 32'd4;
            end
         end
         default: ;
      endcase
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (bif.pc !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h want %h", bif.pc, RST_PC); end
      checks++; if ({bif.done, bif.redirect, bif.taken, bif.timeout_err} !== 4'b0000) begin errors++;
         $display("FAIL reset_pulses: got %b want 0000", {bif.done, bif.redirect, bif.taken, bif.timeout_err}); end
      checks++; if ({bif.alu_req, bif.alu_func3, bif.in_ready} !== 5'b00001) begin errors++;
         $display("FAIL reset_ctrl: got %b want 00001", {bif.alu_req, bif.alu_func3, bif.in_ready}); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_sequential();
      issue(2'b00, 3'd0, 32'h100, 32'h0, 32'h0);
      checks++; if (bif.pc !== 32'h104) begin errors++; $display("FAIL seq_pc: got %h want 00000104", bif.pc); end
      checks++; if ({bif.done, bif.redirect, bif.taken} !== 3'b100) begin errors++;
         $display("FAIL seq_flags: got %b want 100", {bif.done, bif.redirect, bif.taken}); end
      step();
      checks++; if (bif.done !== 1'b0) begin errors++; $display("FAIL seq_done_pulse: got %b want 0", bif.done); end
   endtask

   task automatic test_beq();
      issue(2'b01, 3'd0, 32'h200, 32'h40, 32'h0);
      checks++; if ({bif.in_ready, bif.alu_req, bif.done} !== 3'b010) begin errors++;
         $display("FAIL beq_req: got %b want 010", {bif.in_ready, bif.alu_req, bif.done}); end
      resolve(0, 0, 1'b1, 1'b0);
      checks++; if (bif.pc !== 32'h240) begin errors++; $display("FAIL beq_taken_pc: got %h want 00000240", bif.pc); end
      checks++; if ({bif.done, bif.redirect, bif.taken} !== 3'b111) begin errors++;
         $display("FAIL beq_taken_flags: got %b want 111", {bif.done, bif.redirect, bif.taken}); end
      step();
      checks++; if ({bif.done, bif.redirect, bif.taken, bif.in_ready} !== 4'b0011) begin errors++;
         $display("FAIL beq_hold: got %b want 0011", {bif.done, bif.redirect, bif.taken, bif.in_ready}); end
      issue(2'b01, 3'd0, 32'h200, 32'h40, 32'h0);
      resolve(0, 0, 1'b0, 1'b0);
      checks++; if (bif.pc !== 32'h204) begin errors++; $display("FAIL beq_fall_pc: got %h want 00000204", bif.pc); end
      checks++; if ({bif.done, bif.redirect, bif.taken} !== 3'b100) begin errors++;
         $display("FAIL beq_fall_flags: got %b want 100", {bif.done, bif.redirect, bif.taken}); end
   endtask

   task automatic test_bge_bltu_stall();
      issue(2'b01, 3'd5, 32'h800, 32'hFFFF_FFF0, 32'h0);
      resolve(1, 1, 1'b1, 1'b0);
      checks++; if ({bif.pc, bif.taken, bif.redirect} !== {32'h7F0, 2'b11}) begin errors++;
         $display("FAIL bge_taken: got %h/%b%b want 000007f0/11", bif.pc, bif.taken, bif.redirect); end
      issue(2'b01, 3'd6, 32'h900, 32'h30, 32'h0);
      for (int i = 0; i < 3; i++) begin
         checks++; if ({bif.alu_req, bif.alu_func3} !== 4'b1110) begin errors++;
            $display("FAIL bltu_stall_req: got %b want 1110 (cycle %0d)", {bif.alu_req, bif.alu_func3}, i); end
         // a descriptor offered while busy must not be taken
         bif.in_valid = 1'b1; bif.in_kind = 2'b10; bif.in_pc = 32'hDEAD_0000; bif.in_imm = 32'h10;
         step();
      end
      bif.in_valid = 1'b0;
      checks++; if ({bif.pc, bif.done} !== {32'h7F0, 1'b0}) begin errors++;
         $display("FAIL bltu_busy_pc: got %h/%b want 000007f0/0", bif.pc, bif.done); end
      bif.alu_gnt = 1'b1;
      step();
      bif.alu_gnt = 1'b0;
      checks++; if ({bif.alu_req, bif.alu_func3} !== 4'b0110) begin errors++;
         $display("FAIL bltu_wait_req: got %b want 0110", {bif.alu_req, bif.alu_func3}); end
      bif.alu_done = 1'b1; bif.alu_zero = 1'b1;
      step();
      bif.alu_done = 1'b0;
      checks++; if ({bif.pc, bif.done, bif.taken, bif.redirect} !== {32'h904, 3'b100}) begin errors++;
         $display("FAIL bltu_not_taken: got %h/%b%b%b want 00000904/100", bif.pc, bif.done, bif.taken, bif.redirect); end
   endtask

   task automatic test_jalr();
      issue(2'b11, 3'd0, 32'h3000, 32'h4, 32'h1001);
      checks++; if ({bif.pc, bif.done, bif.taken, bif.redirect} !== {32'h1004, 3'b111}) begin errors++;
         $display("FAIL jalr: got %h/%b%b%b want 00001004/111", bif.pc, bif.done, bif.taken, bif.redirect); end
   endtask

   task automatic test_back_to_back();
      bif.in_valid = 1'b1; bif.in_kind = 2'b10; bif.in_pc = 32'h600; bif.in_imm = 32'h100;
      step();
      checks++; if ({bif.pc, bif.done, bif.redirect, bif.in_ready} !== {32'h700, 3'b111}) begin errors++;
         $display("FAIL b2b_jal: got %h/%b%b%b want 00000700/111", bif.pc, bif.done, bif.redirect, bif.in_ready); end
      bif.in_kind = 2'b00; bif.in_pc = 32'h700;
      step();
      bif.in_valid = 1'b0;
      checks++; if ({bif.pc, bif.done, bif.redirect, bif.taken} !== {32'h704, 3'b100}) begin errors++;
         $display("FAIL b2b_seq: got %h/%b%b%b want 00000704/100", bif.pc, bif.done, bif.redirect, bif.taken); end
      step();
      checks++; if (bif.done !== 1'b0) begin errors++; $display("FAIL b2b_idle_done: got %b want 0", bif.done); end
   endtask

   task automatic test_illegal_func3();
      for (int f = 2; f <= 3; f++) begin
         issue(2'b01, 3'(f), 32'hA00 + 32'(f * 16), 32'h80, 32'h0);
         checks++; if ({bif.pc, bif.done, bif.alu_req, bif.in_ready, bif.redirect} !== {32'hA04 + 32'(f * 16), 4'b1010})
            begin errors++; $display("FAIL illegal_f3_%0d: got %h/%b%b%b%b want %h/1010", f, bif.pc, bif.done,
               bif.alu_req, bif.in_ready, bif.redirect, 32'hA04 + 32'(f * 16)); end
      end
   endtask

   task automatic test_wait_timeout();
      logic seen;
      issue(2'b01, 3'd1, 32'h400, 32'h80, 32'h0);
      bif.alu_gnt = 1'b1;
      step();
      bif.alu_gnt = 1'b0;
`ifdef BRSEQ_TIMEOUT_EN
      seen = 1'b0;
      for (int i = 0; i < TMO - 1; i++) begin
         step();
         seen = seen | bif.done | bif.timeout_err;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b want 0", seen); end
      step();
      checks++; if ({bif.pc, bif.done, bif.timeout_err, bif.taken, bif.redirect} !== {32'h404, 4'b1100}) begin errors++;
         $display("FAIL tmo_abort: got %h/%b%b%b%b want 00000404/1100", bif.pc, bif.done, bif.timeout_err,
                  bif.taken, bif.redirect); end
      step();
      checks++; if ({bif.timeout_err, bif.in_ready} !== 2'b01) begin errors++;
         $display("FAIL tmo_pulse: got %b want 01", {bif.timeout_err, bif.in_ready}); end
`else
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         seen = seen | bif.done | bif.timeout_err | bif.in_ready;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL wait_forever: got %b want 0", seen); end
      bif.alu_done = 1'b1; bif.alu_zero = 1'b0;
      step();
      bif.alu_done = 1'b0;
      checks++; if ({bif.pc, bif.done, bif.taken} !== {32'h480, 2'b11}) begin errors++;
         $display("FAIL wait_late_done: got %h/%b%b want 00000480/11", bif.pc, bif.done, bif.taken); end
`endif
      // result on the last permitted WAIT cycle takes the normal path
      issue(2'b01, 3'd1, 32'h500, 32'h20, 32'h0);
      resolve(0, TMO - 1, 1'b0, 1'b0);
      checks++; if ({bif.pc, bif.done, bif.taken, bif.redirect, bif.timeout_err} !== {32'h520, 4'b1110}) begin errors++;
         $display("FAIL tmo_done_priority: got %h/%b%b%b%b want 00000520/1110", bif.pc, bif.done, bif.taken,
                  bif.redirect, bif.timeout_err); end
   endtask

   task automatic test_reset_midflight();
      issue(2'b01, 3'd0, 32'h300, 32'h40, 32'h0);
      bif.alu_gnt = 1'b1;
      step();
      bif.alu_gnt = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++; if ({bif.alu_req, bif.pc, bif.done, bif.in_ready} !== {1'b0, RST_PC, 2'b01}) begin errors++;
         $display("FAIL rst_mid: got %b/%h/%b%b want 0/%h/01", bif.alu_req, bif.pc, bif.done, bif.in_ready, RST_PC); end
      @(negedge clk);
      rst_n = 1'b1;
      bif.alu_done = 1'b1; bif.alu_zero = 1'b1;
      step();
      bif.alu_done = 1'b0;
      checks++; if ({bif.done, bif.pc, bif.alu_req} !== {1'b0, RST_PC, 1'b0}) begin errors++;
         $display("FAIL rst_stale_done: got %b/%h/%b want 0/%h/0", bif.done, bif.pc, bif.alu_req, RST_PC); end
   endtask

   task automatic test_random();
      logic [1:0]  kind;
      logic [2:0]  f3;
      logic [31:0] ipc, imm, rs1, a, b, npc;
      logic [12:0] r;
      logic        tk, zero, is_br;
      for (int n = 0; n < 80; n++) begin
         kind = 2'($urandom);
         f3   = 3'($urandom);
         ipc  = $urandom & 32'hFFFF_FFFC;
         r    = 13'($urandom);
         imm  = {{19{r[12]}}, r[12:1], 1'b0};
         rs1  = $urandom;
         a    = $urandom;
         b    = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom : a ^ 32'h8000_0000);
         ref_model(kind, f3, ipc, imm, rs1, a, b, npc, tk, zero, is_br);
         issue(kind, f3, ipc, imm, rs1);
         if (is_br) begin
            checks++; if ({bif.done, bif.in_ready, bif.alu_req} !== 3'b001) begin errors++;
               $display("FAIL rnd_busy[%0d]: got %b want 001", n, {bif.done, bif.in_ready, bif.alu_req}); end
            resolve($urandom_range(0, 3), $urandom_range(0, TMO - 1), zero, 1'($urandom));
         end
         checks++; if ({bif.pc, bif.done, bif.taken, bif.redirect} !== {npc, 1'b1, tk, tk}) begin errors++;
            $display("FAIL rnd_retire[%0d] k=%0d f3=%0d: got %h/%b%b%b want %h/1%b%b", n, kind, f3, bif.pc,
                     bif.done, bif.taken, bif.redirect, npc, tk, tk); end
         if ($urandom_range(0, 2) == 0) begin
            bif.alu_gnt = 1'($urandom);
            step();
            bif.alu_gnt = 1'b0;
            checks++; if ({bif.done, bif.alu_req, bif.pc} !== {2'b00, npc}) begin errors++;
               $display("FAIL rnd_idle[%0d]: got %b%b/%h want 00/%h", n, bif.done, bif.alu_req, bif.pc, npc); end
         end
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      bif.in_valid = 1'b0;
      bif.in_kind  = 2'b00;
      bif.in_func3 = 3'd0;
      bif.in_pc    = '0;
      bif.in_imm   = '0;
      bif.in_rs1   = '0;
      bif.alu_gnt  = 1'b0;
      bif.alu_done = 1'b0;
      bif.alu_zero = 1'b0;
      test_reset();
      test_sequential();
      test_beq();
      test_bge_bltu_stall();
      test_jalr();
      test_back_to_back();
      test_illegal_func3();
      test_wait_timeout();
      test_reset_midflight();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
